prga_fifo_wr_skid_buffer: RTL

Write-side companion to the FIFO lookahead buffer: a 2-entry skid buffer between a producer and the write port (`full`/`wr`/`din`) of a `prga_fifo`. The producer sees a fully registered `full` flag, so there is no combinational path from the downstream FIFO's `full` back to the producer. Word order is preserved, throughput is one word per cycle, and a write attempted while full is detected as an error.

---
 rtl/prga_fifo_wr_skid_buffer.sv | 77 +++++++
 1 files changed

// File: rtl/prga_fifo_wr_skid_buffer.sv
// Two-entry write-side skid buffer in front of a prga_fifo write port.
// The producer-facing full flag is registered, so downstream full never reaches it combinationally.
module prga_fifo_wr_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  full,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  full_i,
  output logic                  wr_o,
  output logic [DATA_WIDTH-1:0] din_o,
  output logic [1:0]            cnt,
  output logic                  err_overflow
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_full;
  logic                  r_wp;
  logic                  r_rp;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  w_acc;
  logic                  w_push;

  assign w_acc  = wr && !r_full;
  assign w_push = (r_state != S_EMPTY) && !full_i;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_EMPTY: if (w_acc) w_state_nxt = S_ONE;
      S_ONE: begin
        if (w_acc && !w_push)      w_state_nxt = S_TWO;
        else if (w_push && !w_acc) w_state_nxt = S_EMPTY;
      end
      S_TWO: if (w_push) w_state_nxt = S_ONE;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_EMPTY;
      r_full  <= 1'b0;
      r_wp    <= 1'b0;
      r_rp    <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_full  <= (w_state_nxt == S_TWO);
      if (w_acc)  r_wp <= ~r_wp;
      if (w_push) r_rp <= ~r_rp;
      if (wr && r_full) r_err <= 1'b1;
    end
  end

  // Storage needs no reset; stale words are never visible while cnt is 0.
  always_ff @(posedge clk) begin
    if (w_acc) r_mem[r_wp] <= din;
  end

  assign full         = r_full;
  assign cnt          = r_state;
  assign err_overflow = r_err;
  assign wr_o         = w_push;
  assign din_o        = r_mem[r_rp];

endmodule
